// File: rtl/pc_trace_buffer.sv
// PC trace buffer: captures CPU PC updates into a circular buffer, tags the
// first PC load after an EPC write as the exception vector, and freezes after
// POST further captures. History drains through a one-cycle-latency pop port.
module pc_trace_buffer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int POST  = 4
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          enable_i,
    input  logic          wrap_mode_i,
    input  logic          pc_write_i,
    input  logic [31:0]   pc_value_i,
    input  logic          epc_write_i,
    input  logic          clear_i,
    input  logic          rd_req_i,
    output logic          rd_valid_o,
    output logic [32:0]   rd_data_o,
    output logic [AW:0]   count_o,
    output logic          empty_o,
    output logic          full_o,
    output logic          frozen_o,
    output logic [15:0]   dropped_o
);

    localparam int PW = (POST < 1) ? 1 : $clog2(POST + 1);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_ARMED  = 2'd1,
        S_POST   = 2'd2,
        S_FROZEN = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   post_cnt_q, post_cnt_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic [15:0]     dropped_q, dropped_d;
    logic            rd_valid_q;
    logic [32:0]     rd_data_q;
    logic [32:0]     mem_q [DEPTH];

    logic            accept, pop, tag, is_full, is_empty, drop, mem_we;
    logic            flush;

    assign flush    = reset_i | clear_i;
    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == (AW+1)'(DEPTH));
    assign accept   = pc_write_i & enable_i & (state_q != S_FROZEN);
    assign pop      = rd_req_i & ~is_empty;
    assign tag      = (state_q == S_ARMED) | ((state_q == S_RUN) & epc_write_i);

    // Pointer, occupancy and drop bookkeeping for a capture and/or pop.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        mem_we    = 1'b0;
        drop      = 1'b0;
        if (accept) begin
            if (is_empty) begin
                // A pop against an empty buffer is ignored; capture lands.
                mem_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
                count_d  = count_q + 1'b1;
            end else if (pop) begin
                // Capture and pop together: slot freed by the pop is reused.
                mem_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
                rd_ptr_d = rd_ptr_q + 1'b1;
            end else if (is_full) begin
                drop = 1'b1;
                if (wrap_mode_i) begin
                    mem_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    rd_ptr_d = rd_ptr_q + 1'b1;
                end
            end else begin
                mem_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
                count_d  = count_q + 1'b1;
            end
        end else if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            count_d  = count_q - 1'b1;
        end
        dropped_d = (drop && dropped_q != 16'hFFFF) ? dropped_q + 16'd1 : dropped_q;
    end

    // Exception tracking: FSM advances on accepted strobes, stored or not.
    always_comb begin
        state_d    = state_q;
        post_cnt_d = post_cnt_q;
        unique case (state_q)
            S_RUN: begin
                if (epc_write_i) begin
                    if (accept) begin
                        post_cnt_d = PW'(POST);
                        state_d    = (POST == 0) ? S_FROZEN : S_POST;
                    end else begin
                        state_d = S_ARMED;
                    end
                end
            end
            S_ARMED: begin
                if (accept) begin
                    post_cnt_d = PW'(POST);
                    state_d    = (POST == 0) ? S_FROZEN : S_POST;
                end
            end
            S_POST: begin
                if (accept) begin
                    post_cnt_d = post_cnt_q - 1'b1;
                    if (post_cnt_q == PW'(1)) state_d = S_FROZEN;
                end
            end
            default: ;
        endcase
    end

    // Control state; reset and clear both flush, only reset zeroes rd_data.
    always_ff @(posedge clk_i) begin
        if (flush) begin
            state_q    <= S_RUN;
            post_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            dropped_q  <= '0;
            rd_valid_q <= 1'b0;
            if (reset_i) rd_data_q <= '0;
        end else begin
            state_q    <= state_d;
            post_cnt_q <= post_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            dropped_q  <= dropped_d;
            rd_valid_q <= pop;
            if (pop) rd_data_q <= mem_q[rd_ptr_q];
        end
    end

    // Trace storage; never cleared, contents are only meaningful via count.
    always_ff @(posedge clk_i) begin
        if (mem_we && !flush) mem_q[wr_ptr_q] <= {tag, pc_value_i};
    end

    assign rd_valid_o = rd_valid_q;
    assign rd_data_o  = rd_data_q;
    assign count_o    = count_q;
    assign empty_o    = is_empty;
    assign full_o     = is_full;
    assign frozen_o   = (state_q == S_FROZEN);
    assign dropped_o  = dropped_q;

endmodule

// File: tb/tb_pc_trace_buffer.sv
// Directed bench for pc_trace_buffer: one instance with POST=4 and one with
// POST=0 share all inputs; each scenario flushes before it starts.
module tb_pc_trace_buffer;

    logic        clk = 1'b0;
    logic        reset, enable, wrap_mode, pc_write, epc_write, clear, rd_req;
    logic [31:0] pc_value;

    logic        rd_valid, empty, full, frozen;
    logic [32:0] rd_data;
    logic [4:0]  count;
    logic [15:0] dropped;

    logic        rd_valid0, empty0, full0, frozen0;
    logic [32:0] rd_data0;
    logic [4:0]  count0;
    logic [15:0] dropped0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pc_trace_buffer #(.DEPTH(16), .AW(4), .POST(4)) dut (
        .clk_i(clk), .reset_i(reset), .enable_i(enable), .wrap_mode_i(wrap_mode),
        .pc_write_i(pc_write), .pc_value_i(pc_value), .epc_write_i(epc_write),
        .clear_i(clear), .rd_req_i(rd_req), .rd_valid_o(rd_valid), .rd_data_o(rd_data),
        .count_o(count), .empty_o(empty), .full_o(full), .frozen_o(frozen),
        .dropped_o(dropped)
    );

    pc_trace_buffer #(.DEPTH(16), .AW(4), .POST(0)) dut0 (
        .clk_i(clk), .reset_i(reset), .enable_i(enable), .wrap_mode_i(wrap_mode),
        .pc_write_i(pc_write), .pc_value_i(pc_value), .epc_write_i(epc_write),
        .clear_i(clear), .rd_req_i(rd_req), .rd_valid_o(rd_valid0), .rd_data_o(rd_data0),
        .count_o(count0), .empty_o(empty0), .full_o(full0), .frozen_o(frozen0),
        .dropped_o(dropped0)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic capture(input logic [31:0] v);
        pc_write = 1'b1; pc_value = v;
        tick();
        pc_write = 1'b0;
    endtask

    task automatic pop_chk(input string tag, input logic [32:0] exp);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        chk({tag, "_vld"}, 64'(rd_valid), 64'd1);
        chk({tag, "_dat"}, 64'(rd_data), 64'(exp));
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; wrap_mode = 1'b1; pc_write = 1'b0;
        epc_write = 1'b0; clear = 1'b0; rd_req = 1'b0; pc_value = '0;
        @(negedge clk);
        tick();
        reset = 1'b0;
        chk("rst_vld", 64'(rd_valid), 64'd0);
        chk("rst_dat", 64'(rd_data), 64'd0);
        chk("rst_cnt", 64'(count), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_frozen", 64'(frozen), 64'd0);
        chk("rst_drop", 64'(dropped), 64'd0);

        // Basic ordering
        enable = 1'b1;
        capture(32'h0040_0000);
        chk("b_cnt1", 64'(count), 64'd1);
        capture(32'h0040_0004);
        capture(32'h0040_0008);
        chk("b_cnt3", 64'(count), 64'd3);
        pop_chk("b_p0", 33'h0_0040_0000);
        chk("b_cnt2", 64'(count), 64'd2);
        pop_chk("b_p1", 33'h0_0040_0004);
        pop_chk("b_p2", 33'h0_0040_0008);
        chk("b_cnt0", 64'(count), 64'd0);
        chk("b_empty", 64'(empty), 64'd1);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        chk("b_p3_vld", 64'(rd_valid), 64'd0);
        chk("b_hold", 64'(rd_data), 64'h0_0040_0008);

        // Wrap mode: oldest four overwritten
        do_clear();
        wrap_mode = 1'b1;
        for (int i = 0; i < 20; i++) capture(32'h10 + 32'(4 * i));
        chk("w_full", 64'(full), 64'd1);
        chk("w_cnt", 64'(count), 64'd16);
        chk("w_drop", 64'(dropped), 64'd4);
        for (int i = 4; i < 20; i++) pop_chk($sformatf("w_p%0d", i), 33'(32'h10 + 32'(4 * i)));
        chk("w_empty", 64'(empty), 64'd1);

        // No-wrap: newest four rejected, then clear flushes counters
        do_clear();
        wrap_mode = 1'b0;
        for (int i = 0; i < 20; i++) capture(32'h10 + 32'(4 * i));
        chk("n_cnt", 64'(count), 64'd16);
        chk("n_drop", 64'(dropped), 64'd4);
        for (int i = 0; i < 16; i++) pop_chk($sformatf("n_p%0d", i), 33'(32'h10 + 32'(4 * i)));
        chk("n_drop2", 64'(dropped), 64'd4);
        do_clear();
        chk("c_drop", 64'(dropped), 64'd0);
        chk("c_cnt", 64'(count), 64'd0);

        // Exception then POST=4 captures, then frozen
        wrap_mode = 1'b1;
        tick(); tick(); tick();
        epc_write = 1'b1;
        tick();
        epc_write = 1'b0;
        chk("e_armed_cnt", 64'(count), 64'd0);
        capture(32'h8000_0180);
        capture(32'h0000_00A0);
        capture(32'h0000_00B0);
        capture(32'h0000_00C0);
        chk("e_not_frozen", 64'(frozen), 64'd0);
        capture(32'h0000_00D0);
        chk("e_frozen", 64'(frozen), 64'd1);
        capture(32'h0000_00E0);
        chk("e_cnt", 64'(count), 64'd5);
        chk("e_drop", 64'(dropped), 64'd0);
        pop_chk("e_vec", 33'h1_8000_0180);
        pop_chk("e_a", 33'h0_0000_00A0);
        pop_chk("e_b", 33'h0_0000_00B0);
        pop_chk("e_c", 33'h0_0000_00C0);
        pop_chk("e_d", 33'h0_0000_00D0);
        chk("e_frozen_hold", 64'(frozen), 64'd1);

        // Same-cycle EPC + capture, POST=0 instance freezes on it
        do_clear();
        chk("z_unfrozen", 64'(frozen), 64'd0);
        epc_write = 1'b1;
        capture(32'h8000_0080);
        epc_write = 1'b0;
        chk("z_frozen0", 64'(frozen0), 64'd1);
        chk("z_post4_run", 64'(frozen), 64'd0);
        capture(32'h0000_1234);
        chk("z_cnt0", 64'(count0), 64'd1);
        chk("z_drop0", 64'(dropped0), 64'd0);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        chk("z_vld0", 64'(rd_valid0), 64'd1);
        chk("z_dat0", 64'(rd_data0), 64'h1_8000_0080);
        do_clear();
        chk("z_clr_frozen0", 64'(frozen0), 64'd0);
        chk("z_clr_cnt0", 64'(count0), 64'd0);
        chk("z_clr_hold0", 64'(rd_data0), 64'h1_8000_0080);

        // Full buffer, simultaneous capture and pop, no wrap
        wrap_mode = 1'b0;
        for (int i = 0; i < 16; i++) capture(32'h100 + 32'(i));
        chk("f_full", 64'(full), 64'd1);
        pc_write = 1'b1; pc_value = 32'h999; rd_req = 1'b1;
        tick();
        pc_write = 1'b0; rd_req = 1'b0;
        chk("f_cnt", 64'(count), 64'd16);
        chk("f_drop", 64'(dropped), 64'd0);
        chk("f_vld", 64'(rd_valid), 64'd1);
        chk("f_dat", 64'(rd_data), 64'h100);
        pop_chk("f_p1", 33'h101);

        // Reset during a pop
        reset = 1'b1; rd_req = 1'b1;
        tick();
        reset = 1'b0; rd_req = 1'b0;
        chk("r_vld", 64'(rd_valid), 64'd0);
        chk("r_dat", 64'(rd_data), 64'd0);
        chk("r_cnt", 64'(count), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
